// File: rtl/store_buffer_drain.sv
// rtl/store_buffer_drain.sv - drains store-buffer FIFO packets into single-beat AXI writes
// Holds one latched packet at a time; pulses complete after its write response returns.
module store_buffer_drain #(
  parameter int         DATA_WEDTH = 71,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fifo_empty,
  input  logic [DATA_WEDTH-1:0] fifo_rdata,
  output logic                  complete,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  bus_err,
  output logic [31:0]           bus_err_addr,
  output logic                  drain_idle
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, DONE} state_t;

  state_t                state;
  logic [DATA_WEDTH-1:0] req;
  logic                  aw_pend;
  logic                  w_pend;

  // A channel stays pending until its own handshake; AW and W finish independently.
  always_comb begin
    aw_pend = awvalid && !awready;
    w_pend  = wvalid && !wready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      req          <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      complete     <= 1'b0;
      bus_err      <= 1'b0;
      bus_err_addr <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          complete <= 1'b0;
          if (!fifo_empty) begin
            req     <= fifo_rdata;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          awvalid <= aw_pend;
          wvalid  <= w_pend;
          if (!aw_pend && !w_pend) begin
            bready <= 1'b1;
            state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bvalid) begin
            bready   <= 1'b0;
            complete <= 1'b1;
            state    <= DONE;
            // Only the first failing store is recorded; draining continues regardless.
            if (bresp != 2'b00 && !bus_err) begin
              bus_err      <= 1'b1;
              bus_err_addr <= req[63:32];
            end
          end
        end
        DONE: begin
          complete <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign awid       = AXI_ID;
  assign awaddr     = req[63:32];
  assign awlen      = 8'd0;
  assign awsize     = req[70:68];
  assign awburst    = 2'b01;
  assign wdata      = req[31:0];
  assign wstrb      = req[67:64];
  assign wlast      = 1'b1;
  assign drain_idle = (state == IDLE) && fifo_empty;

endmodule
